dual_regfile: RTL and testbench

//   Register file read by decode and written by the dual-lane writeback stage.

---
 rtl/mips_pkg.sv | 25 ++
 rtl/rf_bypass_read.sv | 38 +++
 rtl/dual_regfile.sv | 87 ++++++++
 tb/tb_dual_regfile.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : mips_pkg
// Brief    : Shared core constants used by decode, hazard unit and regfile.
// Revision : 1.0
// ---------------------------------------------------------------------------
package mips_pkg;

   localparam int WIDTH = 32;
   localparam int NREG  = 32;
   localparam int AW    = 5;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // Writeback lane identifiers; lane B is the younger instruction.
   localparam int LANE_A = 0;
   localparam int LANE_B = 1;
   localparam int NLANES = 2;

   // Read ports per issue lane (rs, rt) and in total.
   localparam int RD_PER_LANE = 2;
   localparam int NRD         = NLANES * RD_PER_LANE;

endpackage
`default_nettype wire

// File: rtl/rf_bypass_read.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : rf_bypass_read
// Brief    : One combinational read port with r0 squash and two-lane bypass.
// Revision : 1.0
// ---------------------------------------------------------------------------
module rf_bypass_read #(
   parameter int WIDTH = mips_pkg::WIDTH,
   parameter int NREG  = mips_pkg::NREG,
   parameter int AW    = mips_pkg::AW
) (
   input  logic                        force_zero,
   input  logic [AW-1:0]               ra,
   input  logic                        we_a,
   input  logic [AW-1:0]               wa_a,
   input  logic [WIDTH-1:0]            wd_a,
   input  logic                        we_b,
   input  logic [AW-1:0]               wa_b,
   input  logic [WIDTH-1:0]            wd_b,
   input  logic [NREG-1:0][WIDTH-1:0]  regs,
   output logic [WIDTH-1:0]            rd
);
   import mips_pkg::*;

   // Lane B is younger, so its in-flight result shadows lane A's.
   always_comb begin
      rd = regs[ra];
      if (force_zero || ra == AW'(REG_ZERO)) begin
         rd = '0;
      end else if (we_b && wa_b == ra) begin
         rd = wd_b;
      end else if (we_a && wa_a == ra) begin
         rd = wd_a;
      end
   end

endmodule
`default_nettype wire

// File: rtl/dual_regfile.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : dual_regfile
// Brief    : Dual-lane writeback register file, four bypassed read ports.
// Revision : 1.0
// ---------------------------------------------------------------------------
module dual_regfile #(
   parameter int WIDTH = mips_pkg::WIDTH,
   parameter int NREG  = mips_pkg::NREG,
   parameter int AW    = mips_pkg::AW
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             we_a,
   input  logic [AW-1:0]    wa_a,
   input  logic [WIDTH-1:0] wd_a,
   input  logic             we_b,
   input  logic [AW-1:0]    wa_b,
   input  logic [WIDTH-1:0] wd_b,
   input  logic [AW-1:0]    ra1,
   input  logic [AW-1:0]    ra2,
   input  logic [AW-1:0]    ra3,
   input  logic [AW-1:0]    ra4,
   output logic [WIDTH-1:0] rd1,
   output logic [WIDTH-1:0] rd2,
   output logic [WIDTH-1:0] rd3,
   output logic [WIDTH-1:0] rd4
);
   import mips_pkg::*;

   logic [WIDTH-1:0]           r_regs [1:NREG-1];
   logic [NREG-1:0][WIDTH-1:0] w_regs;
   logic [AW-1:0]              w_ra [NRD];
   logic [WIDTH-1:0]           w_rd [NRD];

   // Entry 0 has no storage; it is a constant zero row.
   for (genvar gi = 1; gi < NREG; gi++) begin : g_reg
      localparam logic [AW-1:0] c_idx = AW'(gi);
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            r_regs[gi] <= '0;
         end else if (we_b && wa_b == c_idx) begin
            r_regs[gi] <= wd_b;
         end else if (we_a && wa_a == c_idx) begin
            r_regs[gi] <= wd_a;
         end
      end
   end

   always_comb begin
      w_regs    = '0;
      for (int i = 1; i < NREG; i++) begin
         w_regs[i] = r_regs[i];
      end
   end

   assign w_ra[0] = ra1;
   assign w_ra[1] = ra2;
   assign w_ra[2] = ra3;
   assign w_ra[3] = ra4;

   for (genvar gp = 0; gp < NRD; gp++) begin : g_rd
      rf_bypass_read #(
         .WIDTH (WIDTH),
         .NREG  (NREG),
         .AW    (AW)
      ) u_rd (
         .force_zero (reset),
         .ra         (w_ra[gp]),
         .we_a       (we_a),
         .wa_a       (wa_a),
         .wd_a       (wd_a),
         .we_b       (we_b),
         .wa_b       (wa_b),
         .wd_b       (wd_b),
         .regs       (w_regs),
         .rd         (w_rd[gp])
      );
   end

   assign rd1 = w_rd[0];
   assign rd2 = w_rd[1];
   assign rd3 = w_rd[2];
   assign rd4 = w_rd[3];

endmodule
`default_nettype wire

// File: tb/tb_dual_regfile.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// Module   : tb_dual_regfile
// Brief    : Vector table, scoreboard queue and reference-array checks.
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_dual_regfile;

   logic        clk = 1'b0;
   logic        reset;
   logic        we_a, we_b;
   logic [4:0]  wa_a, wa_b, ra1, ra2, ra3, ra4;
   logic [31:0] wd_a, wd_b, rd1, rd2, rd3, rd4;

   int n_total = 0;
   int n_pass  = 0;

   logic [31:0]      model [32];
   logic [3:0][31:0] exq [$];
   string            nameq [$];

   typedef struct {
      logic             we_a;
      logic [4:0]       wa_a;
      logic [31:0]      wd_a;
      logic             we_b;
      logic [4:0]       wa_b;
      logic [31:0]      wd_b;
      logic [3:0][4:0]  ra;
      logic [3:0][31:0] ex;
   } vec_t;

   vec_t vecs [10];

   dual_regfile dut (
      .clk   (clk),
      .reset (reset),
      .we_a  (we_a),
      .wa_a  (wa_a),
      .wd_a  (wd_a),
      .we_b  (we_b),
      .wa_b  (wa_b),
      .wd_b  (wd_b),
      .ra1   (ra1),
      .ra2   (ra2),
      .ra3   (ra3),
      .ra4   (ra4),
      .rd1   (rd1),
      .rd2   (rd2),
      .rd3   (rd3),
      .rd4   (rd4)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, need completion");
      $fatal(1, "timeout");
   end

   function automatic logic [31:0] model_read(input logic [4:0] a);
      if (reset || a == 5'd0)      return 32'd0;
      if (we_b && wa_b == a)       return wd_b;
      if (we_a && wa_a == a)       return wd_a;
      return model[a];
   endfunction

   task automatic drive(input vec_t v);
      we_a = v.we_a; wa_a = v.wa_a; wd_a = v.wd_a;
      we_b = v.we_b; wa_b = v.wa_b; wd_b = v.wd_b;
      ra1 = v.ra[0]; ra2 = v.ra[1]; ra3 = v.ra[2]; ra4 = v.ra[3];
   endtask

   task automatic check_pop();
      logic [3:0][31:0] ex;
      logic [31:0]      got [4];
      string            nm;
      ex = exq.pop_front();
      nm = nameq.pop_front();
      got[0] = rd1; got[1] = rd2; got[2] = rd3; got[3] = rd4;
      for (int p = 0; p < 4; p++) begin
         n_total++;
         if (got[p] === ex[p]) n_pass++;
         else $display("FAIL %s rd%0d: got %h, need %h", nm, p + 1, got[p], ex[p]);
      end
   endtask

   // Drive one cycle, queue expectation, compare mid-cycle, then commit model.
   task automatic step(input vec_t v, input bit use_model, input string nm);
      logic [3:0][31:0] ex;
      drive(v);
      #1;
      if (use_model) begin
         ex[0] = model_read(ra1); ex[1] = model_read(ra2);
         ex[2] = model_read(ra3); ex[3] = model_read(ra4);
      end else begin
         ex = v.ex;
      end
      exq.push_back(ex);
      nameq.push_back(nm);
      @(negedge clk);
      check_pop();
      @(posedge clk);
      if (!reset) begin
         if (we_a && wa_a != 5'd0) model[wa_a] = wd_a;
         if (we_b && wa_b != 5'd0) model[wa_b] = wd_b;
      end
      #1;
   endtask

   function automatic vec_t mk(input logic wea, input logic [4:0] waa, input logic [31:0] wda,
                               input logic web, input logic [4:0] wab, input logic [31:0] wdb,
                               input logic [4:0] r1, input logic [4:0] r2,
                               input logic [4:0] r3, input logic [4:0] r4,
                               input logic [31:0] e1, input logic [31:0] e2,
                               input logic [31:0] e3, input logic [31:0] e4);
      vec_t v;
      v.we_a = wea; v.wa_a = waa; v.wd_a = wda;
      v.we_b = web; v.wa_b = wab; v.wd_b = wdb;
      v.ra = {r4, r3, r2, r1};
      v.ex = {e4, e3, e2, e1};
      return v;
   endfunction

   initial begin
      vec_t v;
      for (int i = 0; i < 32; i++) model[i] = 32'd0;

      vecs[0] = mk(1, 5, 32'hDEADBEEF, 0, 0, 0,          5, 0, 0, 0,
                   32'hDEADBEEF, 0, 0, 0);
      vecs[1] = mk(0, 0, 0, 0, 0, 0,                     5, 5, 0, 0,
                   32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
      vecs[2] = mk(1, 7, 32'h11111111, 1, 7, 32'h22222222, 7, 0, 7, 0,
                   32'h22222222, 0, 32'h22222222, 0);
      vecs[3] = mk(0, 0, 0, 0, 0, 0,                     7, 7, 7, 7,
                   32'h22222222, 32'h22222222, 32'h22222222, 32'h22222222);
      vecs[4] = mk(0, 0, 0, 1, 0, 32'hFFFFFFFF,          0, 0, 0, 0,
                   0, 0, 0, 0);
      vecs[5] = mk(0, 0, 0, 0, 0, 0,                     0, 0, 0, 0,
                   0, 0, 0, 0);
      vecs[6] = mk(1, 3, 32'hA5A5A5A5, 1, 4, 32'h5A5A5A5A, 3, 4, 4, 3,
                   32'hA5A5A5A5, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'hA5A5A5A5);
      vecs[7] = mk(0, 0, 0, 0, 0, 0,                     3, 4, 4, 3,
                   32'hA5A5A5A5, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'hA5A5A5A5);
      vecs[8] = mk(1, 5, 32'h12345678, 1, 6, 32'h0000CAFE, 5, 6, 7, 4,
                   32'h12345678, 32'h0000CAFE, 32'h22222222, 32'h5A5A5A5A);
      vecs[9] = mk(0, 0, 0, 0, 0, 0,                     5, 6, 3, 0,
                   32'h12345678, 32'h0000CAFE, 32'hA5A5A5A5, 0);

      // Power-on reset
      reset = 1'b1;
      drive(mk(0, 0, 0, 0, 0, 0, 1, 2, 3, 4, 0, 0, 0, 0));
      #2;
      exq.push_back('0);
      nameq.push_back("reset_state");
      check_pop();
      @(posedge clk); #1;
      reset = 1'b0;

      for (int i = 0; i < 10; i++) step(vecs[i], 1'b0, $sformatf("vec%0d", i));

      for (int c = 0; c < 10000; c++) begin
         v = mk($urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom,
                $urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom,
                5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 0, 0, 0, 0);
         if (c % 8 == 0) v.wa_b = v.wa_a;
         if (c % 5 == 0) v.ra[c % 4] = v.wa_a;
         step(v, 1'b1, "random");
      end

      // Load known values, then assert reset between edges with writes pending
      step(mk(1, 9, 32'h99999999, 1, 10, 32'hAAAA0000, 9, 10, 0, 0,
              32'h99999999, 32'hAAAA0000, 0, 0), 1'b0, "preload");
      drive(mk(1, 9, 32'h12121212, 1, 11, 32'h34343434, 9, 10, 11, 9, 0, 0, 0, 0));
      #2;
      reset = 1'b1;
      #1;
      exq.push_back('0);
      nameq.push_back("reset_async");
      check_pop();
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
      @(posedge clk); #1;
      exq.push_back('0);
      nameq.push_back("reset_held");
      check_pop();
      reset = 1'b0;
      step(mk(0, 0, 0, 0, 0, 0, 9, 10, 11, 9, 0, 0, 0, 0), 1'b0, "after_reset");
      step(mk(1, 12, 32'h0BADF00D, 0, 0, 0, 12, 1, 2, 3,
              32'h0BADF00D, 0, 0, 0), 1'b0, "first_write");
      step(mk(0, 0, 0, 0, 0, 0, 12, 12, 0, 12,
              32'h0BADF00D, 32'h0BADF00D, 0, 32'h0BADF00D), 1'b0, "first_write_hold");

      for (int c = 0; c < 200; c++) begin
         v = mk($urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom,
                $urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom,
                5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 0, 0, 0, 0);
         step(v, 1'b1, "random_post");
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
